// File: rtl/types.sv
// Shared flit types for the link layer: header fields, flit type codes and
// the packed flit carried between checksum stage and receive buffer.
package types;

  typedef enum logic [1:0] {
    NOPE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2,
    TAIL = 2'd3
  } flittype_t;

  typedef struct packed {
    flittype_t  flittype;
    logic [3:0] src_id;
    logic [3:0] dst_id;
  } header_t;

  typedef struct packed {
    header_t     header;
    logic [31:0] payload;
    logic [7:0]  checksum;
  } flit_t;

endpackage

// File: rtl/flit_rx_buffer.sv
// Receive buffer after the checksum stage: drops and counts bad flits,
// optionally drops NOPE flits, and queues good flits in a FWFT FIFO.
module flit_rx_buffer #(
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8,
  parameter bit DROP_NOPE = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  types::flit_t                 flit_in,
  input  logic                         checksum_ok,
  input  logic                         flit_in_valid,
  output logic                         flit_in_ready,
  output types::flit_t                 flit_out,
  output logic                         flit_out_valid,
  input  logic                         flit_out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         drop_pulse,
  output logic [CNT_W-1:0]             drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  types::flit_t      storage_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [OCC_W-1:0]  occ_r;
  logic              drop_pulse_r;
  logic [CNT_W-1:0]  drop_count_r;

  logic accept_s;
  logic nope_s;
  logic write_s;
  logic bad_s;
  logic pop_s;

  // Full buffer never accepts, even when a pop happens in the same cycle.
  assign flit_in_ready  = (occ_r != OCC_FULL);
  assign flit_out_valid = (occ_r != OCC_ZERO);
  assign flit_out       = storage_r[rd_ptr_r];
  assign occupancy      = occ_r;
  assign drop_pulse     = drop_pulse_r;
  assign drop_count     = drop_count_r;

  // Classify the flit being accepted this cycle and detect a pop.
  always_comb begin
    accept_s = flit_in_valid && flit_in_ready;
    nope_s   = (flit_in.header.flittype == types::NOPE);
    bad_s    = accept_s && !checksum_ok;
    pop_s    = flit_out_valid && flit_out_ready;
    if (accept_s && checksum_ok) begin
      write_s = !(DROP_NOPE && nope_s);
    end else begin
      write_s = 1'b0;
    end
  end

  // FIFO storage, pointers, occupancy and drop statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage_r[i] <= '0;
      end
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      occ_r        <= OCC_ZERO;
      drop_pulse_r <= 1'b0;
      drop_count_r <= {CNT_W{1'b0}};
    end else begin
      if (write_s) begin
        storage_r[wr_ptr_r] <= flit_in;
        wr_ptr_r            <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({write_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
      drop_pulse_r <= bad_s;
      if (bad_s && (drop_count_r != CNT_MAX)) begin
        drop_count_r <= drop_count_r + CNT_ONE;
      end
    end
  end

endmodule
